// File: rtl/parking_gate_pkg.sv
// Shared types and default timing constants for the parking gate controller.
package parking_gate_pkg;

    typedef enum logic [2:0] {
        GS_IDLE    = 3'd0,
        GS_CHECK   = 3'd1,
        GS_OPEN    = 3'd2,
        GS_HOLD    = 3'd3,
        GS_RELEASE = 3'd4
    } gate_state_e;

    localparam int unsigned DEF_OPEN_HOLD    = 32'd4;
    localparam int unsigned DEF_PASS_TIMEOUT = 32'd16;
    localparam int unsigned DEF_TMR_W        = 32'd5;

    function automatic logic state_drives_open(input gate_state_e s);
        return (s == GS_OPEN) || (s == GS_HOLD);
    endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier sequencer: optional vacancy check, pass window with timeout,
// post-pass hold, and release that waits for the loop sensor to clear.
module parking_gate_fsm
    import parking_gate_pkg::*;
#(
    parameter int unsigned OPEN_HOLD    = DEF_OPEN_HOLD,
    parameter int unsigned PASS_TIMEOUT = DEF_PASS_TIMEOUT,
    parameter int unsigned TMR_W        = DEF_TMR_W,
    parameter bit          CHECK_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic req_is_uni,
    input  logic pass,
    input  logic uni_vacant,
    input  logic gen_vacant,
    output logic gate_open,
    output logic is_uni,
    output logic event_req,
    output logic denied,
    output logic timeout
);

    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(PASS_TIMEOUT - 32'd1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(OPEN_HOLD - 32'd1);

    gate_state_e      state_r, state_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic             uni_r, uni_s;
    logic             gate_open_r, denied_r, timeout_r;
    logic             denied_s, timeout_s, event_s;

    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
        return (t == {TMR_W{1'b1}}) ? t : t + TMR_W'(1'b1);
    endfunction

    // Next-state, timer and pulse decode.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        uni_s     = uni_r;
        denied_s  = 1'b0;
        timeout_s = 1'b0;
        event_s   = 1'b0;
        case (state_r)
            GS_IDLE: begin
                if (req) begin
                    uni_s   = req_is_uni;
                    timer_s = '0;
                    state_s = CHECK_EN ? GS_CHECK : GS_OPEN;
                end else begin
                    state_s = GS_IDLE;
                end
            end
            GS_CHECK: begin
                if ((uni_r && uni_vacant) || (!uni_r && gen_vacant)) begin
                    timer_s = '0;
                    state_s = GS_OPEN;
                end else begin
                    denied_s = 1'b1;
                    state_s  = GS_RELEASE;
                end
            end
            GS_OPEN: begin
                if (pass) begin
                    event_s = 1'b1;
                    timer_s = '0;
                    state_s = GS_HOLD;
                end else if (timer_r >= TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = GS_RELEASE;
                end else begin
                    timer_s = tmr_inc(timer_r);
                end
            end
            GS_HOLD: begin
                // Late pass pulses are deliberately ignored: a tailgater is not counted.
                if (timer_r >= HOLD_LAST) begin
                    state_s = GS_RELEASE;
                end else begin
                    timer_s = tmr_inc(timer_r);
                end
            end
            GS_RELEASE: begin
                if (!req) begin
                    state_s = GS_IDLE;
                end else begin
                    state_s = GS_RELEASE;
                end
            end
            default: begin
                state_s = GS_IDLE;
                timer_s = '0;
            end
        endcase
    end

    // State, timer and registered barrier/pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= GS_IDLE;
            timer_r     <= '0;
            uni_r       <= 1'b0;
            gate_open_r <= 1'b0;
            denied_r    <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            uni_r       <= uni_s;
            gate_open_r <= state_drives_open(state_s);
            denied_r    <= denied_s;
            timeout_r   <= timeout_s;
        end
    end

    assign gate_open = gate_open_r;
    assign is_uni    = uni_r;
    assign event_req = event_s;
    assign denied    = denied_r;
    assign timeout   = timeout_r;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller top: two barrier sequencers plus the event arbiter
// that serialises entry/exit events towards the occupancy module.
module parking_gate_ctrl
    import parking_gate_pkg::*;
#(
    parameter int unsigned OPEN_HOLD    = DEF_OPEN_HOLD,
    parameter int unsigned PASS_TIMEOUT = DEF_PASS_TIMEOUT,
    parameter int unsigned TMR_W        = DEF_TMR_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_req,
    input  logic       entry_is_uni,
    input  logic       entry_pass,
    input  logic       exit_req,
    input  logic       exit_is_uni,
    input  logic       exit_pass,
    input  logic       uni_is_vacated_space,
    input  logic       is_vacated_space,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited,
    output logic       entry_gate_open,
    output logic       exit_gate_open,
    output logic       entry_denied,
    output logic [1:0] gate_timeout
);

    logic entry_ev_s, entry_uni_s, entry_to_s;
    logic exit_ev_s, exit_uni_s, exit_to_s, exit_denied_unused_s;

    parking_gate_fsm #(
        .OPEN_HOLD(OPEN_HOLD), .PASS_TIMEOUT(PASS_TIMEOUT), .TMR_W(TMR_W), .CHECK_EN(1'b1)
    ) u_entry (
        .clk(clk), .rst_n(rst_n),
        .req(entry_req), .req_is_uni(entry_is_uni), .pass(entry_pass),
        .uni_vacant(uni_is_vacated_space), .gen_vacant(is_vacated_space),
        .gate_open(entry_gate_open), .is_uni(entry_uni_s), .event_req(entry_ev_s),
        .denied(entry_denied), .timeout(entry_to_s)
    );

    parking_gate_fsm #(
        .OPEN_HOLD(OPEN_HOLD), .PASS_TIMEOUT(PASS_TIMEOUT), .TMR_W(TMR_W), .CHECK_EN(1'b0)
    ) u_exit (
        .clk(clk), .rst_n(rst_n),
        .req(exit_req), .req_is_uni(exit_is_uni), .pass(exit_pass),
        .uni_vacant(1'b0), .gen_vacant(1'b1),
        .gate_open(exit_gate_open), .is_uni(exit_uni_s), .event_req(exit_ev_s),
        .denied(exit_denied_unused_s), .timeout(exit_to_s)
    );

    logic car_entered_r, uni_entered_r, car_exited_r, uni_exited_r;
    logic pend_r, pend_uni_r;
    logic ent_fire_s, ent_cat_s, ex_cat_s, pend_s, pend_uni_s;

    // Arbiter: exit wins a shared cycle, the entry waits one cycle in the pending slot.
    always_comb begin
        ent_fire_s = 1'b0;
        ent_cat_s  = uni_entered_r;
        pend_s     = pend_r;
        pend_uni_s = pend_uni_r;
        ex_cat_s   = exit_ev_s ? exit_uni_s : uni_exited_r;
        if (exit_ev_s) begin
            if (entry_ev_s) begin
                pend_s     = 1'b1;
                pend_uni_s = entry_uni_s;
            end else begin
                pend_s = pend_r;
            end
        end else if (pend_r) begin
            ent_fire_s = 1'b1;
            ent_cat_s  = pend_uni_r;
            if (entry_ev_s) begin
                pend_uni_s = entry_uni_s;
            end else begin
                pend_s = 1'b0;
            end
        end else if (entry_ev_s) begin
            ent_fire_s = 1'b1;
            ent_cat_s  = entry_uni_s;
        end else begin
            ent_fire_s = 1'b0;
        end
    end

    // Registered event outputs and pending-entry slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car_entered_r <= 1'b0;
            uni_entered_r <= 1'b0;
            car_exited_r  <= 1'b0;
            uni_exited_r  <= 1'b0;
            pend_r        <= 1'b0;
            pend_uni_r    <= 1'b0;
        end else begin
            car_entered_r <= ent_fire_s;
            uni_entered_r <= ent_cat_s;
            car_exited_r  <= exit_ev_s;
            uni_exited_r  <= ex_cat_s;
            pend_r        <= pend_s;
            pend_uni_r    <= pend_uni_s;
        end
    end

    assign car_entered        = car_entered_r;
    assign is_uni_car_entered = uni_entered_r;
    assign car_exited         = car_exited_r;
    assign is_uni_car_exited  = uni_exited_r;
    assign gate_timeout       = {exit_to_s, entry_to_s};

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed vector table, corner sequences and
// randomized traffic checked against a counter/queue based reference model.
module tb_parking_gate_ctrl;

    localparam int OPEN_HOLD    = 4;
    localparam int PASS_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0, entry_is_uni = 1'b0, entry_pass = 1'b0;
    logic       exit_req = 1'b0, exit_is_uni = 1'b0, exit_pass = 1'b0;
    logic       uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
    logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic       entry_gate_open, exit_gate_open, entry_denied;
    logic [1:0] gate_timeout;

    parking_gate_ctrl #(.OPEN_HOLD(OPEN_HOLD), .PASS_TIMEOUT(PASS_TIMEOUT), .TMR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .entry_req(entry_req), .entry_is_uni(entry_is_uni), .entry_pass(entry_pass),
        .exit_req(exit_req), .exit_is_uni(exit_is_uni), .exit_pass(exit_pass),
        .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .entry_gate_open(entry_gate_open), .exit_gate_open(exit_gate_open),
        .entry_denied(entry_denied), .gate_timeout(gate_timeout)
    );

    always #5 clk = ~clk;

    // {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    //  entry_gate_open, exit_gate_open, entry_denied, gate_timeout[1:0]}
    logic [8:0] out_v;
    assign out_v = {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
                    entry_gate_open, exit_gate_open, entry_denied, gate_timeout};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a gate is busy from req until released; it counts down a
    // pass window and a hold window; entry events go through a FIFO that yields to exits.
    bit m_busy[2], m_check[2], m_cat[2];
    int m_win[2], m_hold[2];
    bit q_ent[$];
    bit x_ce, x_uce, x_cx, x_ucx, x_den;
    bit [1:0] x_to;

    function automatic void model_reset();
        for (int g = 0; g < 2; g++) begin
            m_busy[g] = 1'b0; m_check[g] = 1'b0; m_cat[g] = 1'b0;
            m_win[g] = 0; m_hold[g] = 0;
        end
        q_ent.delete();
        x_ce = 1'b0; x_uce = 1'b0; x_cx = 1'b0; x_ucx = 1'b0; x_den = 1'b0; x_to = 2'b00;
    endfunction

    function automatic void model_step();
        bit req[2], uni[2], pass[2], ev[2];
        bool_dummy();
        req[0] = entry_req; uni[0] = entry_is_uni; pass[0] = entry_pass;
        req[1] = exit_req;  uni[1] = exit_is_uni;  pass[1] = exit_pass;
        x_den = 1'b0; x_to = 2'b00;
        for (int g = 0; g < 2; g++) begin
            ev[g] = 1'b0;
            if (!m_busy[g]) begin
                if (req[g]) begin
                    m_busy[g] = 1'b1;
                    m_cat[g]  = uni[g];
                    if (g == 0) m_check[g] = 1'b1;
                    else        m_win[g] = PASS_TIMEOUT;
                end
            end else if (m_check[g]) begin
                m_check[g] = 1'b0;
                if (m_cat[g] ? uni_is_vacated_space : is_vacated_space) m_win[g] = PASS_TIMEOUT;
                else x_den = 1'b1;
            end else if (m_win[g] > 0) begin
                if (pass[g]) begin
                    ev[g] = 1'b1; m_win[g] = 0; m_hold[g] = OPEN_HOLD;
                end else begin
                    m_win[g]--;
                    if (m_win[g] == 0) x_to[g] = 1'b1;
                end
            end else if (m_hold[g] > 0) begin
                m_hold[g]--;
            end else if (!req[g]) begin
                m_busy[g] = 1'b0;
            end
        end
        if (ev[0]) q_ent.push_back(m_cat[0]);
        x_cx = ev[1];
        if (ev[1]) x_ucx = m_cat[1];
        x_ce = 1'b0;
        if (!ev[1] && q_ent.size() > 0) begin
            x_ce  = 1'b1;
            x_uce = q_ent.pop_front();
        end
    endfunction

    function automatic void bool_dummy();
    endfunction

    function automatic logic [8:0] model_out();
        return {x_ce, x_uce, x_cx, x_ucx,
                (m_win[0] > 0) || (m_hold[0] > 0), (m_win[1] > 0) || (m_hold[1] > 0),
                x_den, x_to};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
    endtask

    typedef struct {
        logic [7:0] stim;  // {e_req, e_uni, e_pass, x_req, x_uni, x_pass, uni_vac, vac}
        logic [8:0] exp;
    } vec_t;
    vec_t vecs [16];

    initial begin
        int pass_rate;
        vecs[0]  = '{8'b1100_0010, 9'b000000000};
        vecs[1]  = '{8'b1100_0010, 9'b000010000};
        vecs[2]  = '{8'b1100_0010, 9'b000010000};
        vecs[3]  = '{8'b1100_0010, 9'b000010000};
        vecs[4]  = '{8'b1110_0010, 9'b110010000};
        vecs[5]  = '{8'b1100_0010, 9'b010010000};
        vecs[6]  = '{8'b1110_0010, 9'b010010000};
        vecs[7]  = '{8'b1100_0010, 9'b010010000};
        vecs[8]  = '{8'b1100_0010, 9'b010000000};
        vecs[9]  = '{8'b1100_0010, 9'b010000000};
        vecs[10] = '{8'b0000_0010, 9'b010000000};
        vecs[11] = '{8'b1000_0010, 9'b010000000};
        vecs[12] = '{8'b1000_0010, 9'b010000100};
        vecs[13] = '{8'b1000_0010, 9'b010000000};
        vecs[14] = '{8'b1000_0010, 9'b010000000};
        vecs[15] = '{8'b0000_0010, 9'b010000000};

        model_reset();
        repeat (3) tick();
        chk("reset_state", out_v, 9'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            {entry_req, entry_is_uni, entry_pass, exit_req, exit_is_uni, exit_pass,
             uni_is_vacated_space, is_vacated_space} = vecs[i].stim;
            tick();
            chk($sformatf("vec%0d", i), out_v, vecs[i].exp);
        end

        // Same-cycle entry and exit pass: exit first, entry one cycle later.
        entry_req = 1'b1; entry_is_uni = 1'b0; is_vacated_space = 1'b1;
        exit_req = 1'b1; exit_is_uni = 1'b1;
        tick(); tick();
        entry_pass = 1'b1; exit_pass = 1'b1;
        tick();
        chk("same_cycle_exit", {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, 5'b0},
            9'b0111_00000);
        entry_pass = 1'b0; exit_pass = 1'b0;
        tick();
        chk("same_cycle_entry", {car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, 5'b0},
            9'b1001_00000);
        tick();
        chk("same_cycle_drained", {car_entered, car_exited, 7'b0}, 9'b0);
        entry_req = 1'b0; exit_req = 1'b0;
        repeat (8) tick();

        // Exit pass window expires with no pass.
        exit_req = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk($sformatf("exit_timeout_c%0d", i), {car_exited, exit_gate_open, gate_timeout, 5'b0},
                {1'b0, (i <= 15) ? 1'b1 : 1'b0, (i == 16) ? 1'b1 : 1'b0, 1'b0, 5'b0});
        end
        exit_req = 1'b0;
        repeat (2) tick();

        // Reset while the entry barrier is open.
        entry_req = 1'b1; entry_is_uni = 1'b0; is_vacated_space = 1'b1;
        tick(); tick();
        chk("pre_reset_open", {entry_gate_open, 8'b0}, 9'b1_0000_0000);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", out_v, 9'b0);
        entry_req = 1'b0; entry_pass = 1'b1;
        tick(); tick();
        rst_n = 1'b1; entry_pass = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_reset_c%0d", i), out_v, 9'b0);
        end

        // Randomized traffic against the reference model.
        pass_rate = 6;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) pass_rate = (c % 600 == 0) ? 2 : ((c % 400 == 0) ? 30 : 6);
            if ($urandom_range(0, 9) == 0) entry_req = ~entry_req;
            if ($urandom_range(0, 9) == 0) exit_req = ~exit_req;
            entry_is_uni = 1'($urandom_range(0, 1));
            exit_is_uni  = 1'($urandom_range(0, 1));
            entry_pass   = ($urandom_range(0, pass_rate - 1) == 0);
            exit_pass    = ($urandom_range(0, pass_rate - 1) == 0);
            uni_is_vacated_space = ($urandom_range(0, 3) != 0);
            is_vacated_space     = ($urandom_range(0, 2) != 0);
            tick();
            chk($sformatf("rand_c%0d", c), out_v, model_out());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
